// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one request at a time to a
// variable-latency memory and hands each instruction to decode under valid/stall.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_done_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] instr_o,
    output logic        instr_valid_o,
    output logic [15:0] pc_out_o,
    output logic [15:0] pc_plus2_o,
    output logic        halted_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StDeliver,
        StDrain,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        err_q, err_d;
    logic        redirect_act;

    // HALTED is terminal: redirects are not honoured there.
    assign redirect_act = redirect_i && (state_q != StHalted);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            pc_out_q   <= 16'h0000;
            pc_plus2_q <= 16'h0002;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus2_q <= pc_plus2_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus2_d = pc_plus2_q;
        err_d      = err_q;

        if (redirect_act) begin
            pc_d = redirect_pc_i;
            if (ALIGN_CHECK && redirect_pc_i[0]) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                StWait, StDrain: state_d = imem_done_i ? StFetch : StDrain;
                default:         state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: state_d = StWait;
                StWait: begin
                    if (imem_done_i) begin
                        instr_d    = imem_data_i;
                        pc_out_d   = pc_q;
                        pc_plus2_d = pc_q + 16'd2;
                        state_d    = StDeliver;
                    end
                end
                StDeliver: begin
                    if (!stall_i) begin
                        if (halt_i) begin
                            state_d = StHalted;
                        end else begin
                            pc_d = pc_q + 16'd2;
                            if (pc_q == 16'hFFFE) begin
                                err_d = 1'b1;
                            end
                            state_d = StFetch;
                        end
                    end
                end
                StDrain: begin
                    if (imem_done_i) begin
                        state_d = StFetch;
                    end
                end
                StHalted: state_d = StHalted;
                default:  state_d = StFetch;
            endcase
        end
    end

    always_comb begin
        imem_req_o    = (state_q == StFetch) && !redirect_i && !rst_i;
        imem_addr_o   = pc_q;
        instr_o       = instr_q;
        instr_valid_o = (state_q == StDeliver);
        pc_out_o      = pc_out_q;
        pc_plus2_o    = pc_plus2_q;
        halted_o      = (state_q == StHalted);
        err_o         = err_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle-by-cycle vector table plus hand-written
// sequences for halt/redirect, wrap, misalignment and asynchronous reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        err;

    int tests = 0;
    int fails = 0;

    fetch_ctrl #(
        .RESET_PC   (16'h0000),
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .stall_i      (stall),
        .halt_i       (halt),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_done_i  (imem_done),
        .imem_data_i  (imem_data),
        .instr_o      (instr),
        .instr_valid_o(instr_valid),
        .pc_out_o     (pc_out),
        .pc_plus2_o   (pc_plus2),
        .halted_o     (halted),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [15:0] rpc;
        logic        stl;
        logic        hlt_in;
        logic        done;
        logic [15:0] data;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ins;
        logic [15:0] pco;
        logic        hlt;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic [15:0] rp, logic st, logic hi, logic dn,
                                logic [15:0] dt, logic rq, logic [15:0] ad, logic vl,
                                logic [15:0] in, logic [15:0] po, logic ho, logic e);
        vec_t v;
        v.redir = rd; v.rpc = rp; v.stl = st; v.hlt_in = hi; v.done = dn; v.data = dt;
        v.req = rq; v.addr = ad; v.vld = vl; v.ins = in; v.pco = po; v.hlt = ho; v.er = e;
        return v;
    endfunction

    task automatic drive(logic rd, logic [15:0] rp, logic st, logic hi, logic dn,
                         logic [15:0] dt);
        redirect = rd; redirect_pc = rp; stall = st; halt = hi; imem_done = dn; imem_data = dt;
        #1;
    endtask

    task automatic chk(string name, logic rq, logic [15:0] ad, logic vl, logic [15:0] in,
                       logic [15:0] po, logic ho, logic e);
        logic [15:0] p2;
        p2 = po + 16'd2;
        tests++;
        if (imem_req !== rq || imem_addr !== ad || instr_valid !== vl || instr !== in ||
            pc_out !== po || pc_plus2 !== p2 || halted !== ho || err !== e) begin
            fails++;
            $display("FAIL %s: got req=%b addr=%h vld=%b instr=%h pc_out=%h pc_plus2=%h halted=%b err=%b ; want req=%b addr=%h vld=%b instr=%h pc_out=%h pc_plus2=%h halted=%b err=%b",
                     name, imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus2, halted,
                     err, rq, ad, vl, in, po, p2, ho, e);
        end
    endtask

    // Drive at the falling edge, check 1ns later, then advance one full cycle.
    task automatic cyc(string name, logic rd, logic [15:0] rp, logic st, logic hi, logic dn,
                       logic [15:0] dt, logic rq, logic [15:0] ad, logic vl,
                       logic [15:0] in, logic [15:0] po, logic ho, logic e);
        drive(rd, rp, st, hi, dn, dt);
        chk(name, rq, ad, vl, in, po, ho, e);
        @(negedge clk);
    endtask

    task automatic do_reset(string name);
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk(name, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        do_reset("reset");

        // Sequential fetch 0,2,4 with 1-cycle memory.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'hA000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0000, 1, 16'hA000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0002, 0, 16'hA000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'hA002, 0, 16'h0002, 0, 16'hA000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0002, 1, 16'hA002, 16'h0002, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0004, 0, 16'hA002, 16'h0002, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'hA004, 0, 16'h0004, 0, 16'hA002, 16'h0002, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0004, 1, 16'hA004, 16'h0004, 0, 0));
        // Stall hold at pc_out=6 for 4 cycles, then next request at 8.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0006, 0, 16'hA004, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h1234, 0, 16'h0006, 0, 16'hA004, 16'h0004, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 16'h0006, 1, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0006, 1, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0008, 0, 16'h1234, 16'h0006, 0, 0));
        // Redirect to 0x40 one cycle after the request, 3-cycle memory; stale data dropped.
        vecs.push_back(mk(1, 16'h0040, 0, 0, 0, 0, 0, 16'h0008, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0040, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'hDEAD, 0, 16'h0040, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0040, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0040, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0040, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h5555, 0, 16'h0040, 0, 16'h1234, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0040, 1, 16'h5555, 16'h0040, 0, 0));
        // Halt alone: stalled halt holds, then halt enters HALTED; redirect ignored there.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       1, 16'h0042, 0, 16'h5555, 16'h0040, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h6666, 0, 16'h0042, 0, 16'h5555, 16'h0040, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,       0, 16'h0042, 1, 16'h6666, 16'h0042, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,       0, 16'h0042, 1, 16'h6666, 16'h0042, 0, 0));
        vecs.push_back(mk(1, 16'h0080, 0, 0, 1, 16'h7777, 0, 16'h0042, 0, 16'h6666, 16'h0042, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 16'h0042, 0, 16'h6666, 16'h0042, 1, 0));

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].redir, vecs[i].rpc, vecs[i].stl,
                vecs[i].hlt_in, vecs[i].done, vecs[i].data, vecs[i].req, vecs[i].addr,
                vecs[i].vld, vecs[i].ins, vecs[i].pco, vecs[i].hlt, vecs[i].er);
        end

        // Halt together with an odd redirect: redirect wins, err set by misalignment.
        do_reset("reset2");
        cyc("hr_fetch", 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("hr_wait", 0, 0, 0, 0, 1, 16'h1111, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("hr_both", 1, 16'h0011, 0, 1, 0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 0, 0);
        cyc("hr_after", 0, 0, 0, 0, 0, 0, 1, 16'h0011, 0, 16'h1111, 16'h0000, 0, 1);
        cyc("wait_redir_done", 1, 16'h0100, 0, 0, 1, 16'hBAD0, 0, 16'h0011, 0, 16'h1111,
            16'h0000, 0, 1);
        cyc("fetch_redir", 1, 16'h0200, 0, 0, 0, 0, 0, 16'h0100, 0, 16'h1111, 16'h0000, 0, 1);
        cyc("fetch_new", 0, 0, 0, 0, 0, 0, 1, 16'h0200, 0, 16'h1111, 16'h0000, 0, 1);

        // PC wrap from 0xFFFE sets err, which stays set.
        do_reset("reset3");
        cyc("w_redir", 1, 16'hFFFE, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("w_fetch", 0, 0, 0, 0, 0, 0, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("w_wait", 0, 0, 0, 0, 1, 16'h2222, 0, 16'hFFFE, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("w_deliver", 0, 0, 0, 0, 0, 0, 0, 16'hFFFE, 1, 16'h2222, 16'hFFFE, 0, 0);
        cyc("w_wrapped", 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 16'h2222, 16'hFFFE, 0, 1);
        cyc("w_wait2", 0, 0, 0, 0, 1, 16'h3333, 0, 16'h0000, 0, 16'h2222, 16'hFFFE, 0, 1);
        cyc("w_deliver2", 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h3333, 16'h0000, 0, 1);
        cyc("w_fetch2", 0, 0, 0, 0, 0, 0, 1, 16'h0002, 0, 16'h3333, 16'h0000, 0, 1);

        // Asynchronous reset while WAIT has a request outstanding.
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_arst", 1'b0, 16'h0002, 1'b0, 16'h3333, 16'h0000, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_now", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc("late_done", 0, 0, 0, 0, 1, 16'hBEEF, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("post_wait", 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("post_done", 0, 0, 0, 0, 1, 16'h4444, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        cyc("post_deliver", 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h4444, 16'h0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
